// File: rtl/bfp_stage_ctrl.sv
// Block-floating-point stage controller for the in-place FFT.
// Each stage clears the bit-width tracker and passes butterfly writes through
// as tracker activations. At the end of the stage it turns the tracker result
// into the shift for the next stage and adds that shift to the block exponent.
module bfp_stage_ctrl #(
  parameter int FFT_MAX_BIT_WIDTH = 5,
  parameter int NUM_STAGES        = 10,
  parameter int STAGE_W           = 4,
  parameter int BFLY_PER_STAGE    = 512,
  parameter int BFLY_CNT_W        = 10,
  parameter int TARGET_BIT_WIDTH  = 14,
  parameter int MAX_SHIFT         = 3,
  parameter int EXP_W             = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         bfly_valid_i,
  input  logic [FFT_MAX_BIT_WIDTH-1:0] tracker_max_i,
  output logic                         tracker_clr_o,
  output logic                         tracker_activate_o,
  output logic                         busy_o,
  output logic                         stage_start_o,
  output logic [STAGE_W-1:0]           stage_idx_o,
  output logic [FFT_MAX_BIT_WIDTH-1:0] stage_shift_o,
  output logic [EXP_W-1:0]             block_exponent_o,
  output logic                         done_o
);

  localparam int SW = ((EXP_W > FFT_MAX_BIT_WIDTH) ? EXP_W : FFT_MAX_BIT_WIDTH) + 1;
  localparam logic [FFT_MAX_BIT_WIDTH-1:0] TGT        = FFT_MAX_BIT_WIDTH'(TARGET_BIT_WIDTH);
  localparam logic [FFT_MAX_BIT_WIDTH-1:0] SHIFT_MAX  = FFT_MAX_BIT_WIDTH'(MAX_SHIFT);
  localparam logic [STAGE_W-1:0]           LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [BFLY_CNT_W-1:0]        LAST_BFLY  = BFLY_CNT_W'(BFLY_PER_STAGE - 1);
  localparam logic [EXP_W-1:0]             EXP_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_LATCH, S_DONE
  } state_t;

  state_t                         state_q;
  logic                           busy_q, done_q, stage_start_q, clr_q;
  logic [STAGE_W-1:0]             stage_idx_q;
  logic [FFT_MAX_BIT_WIDTH-1:0]   shift_q;
  logic [EXP_W-1:0]               exp_q;
  logic [BFLY_CNT_W-1:0]          cnt_q;

  logic [FFT_MAX_BIT_WIDTH-1:0]   over_d, shift_d;
  logic [SW-1:0]                  exp_sum_d;
  logic [EXP_W-1:0]               exp_d;

  // Shift for the next stage from the tracker result, and the saturated exponent sum.
  always_comb begin
    over_d  = '0;
    shift_d = '0;
    if (tracker_max_i > TGT) begin
      over_d  = tracker_max_i - TGT;
      shift_d = (over_d > SHIFT_MAX) ? SHIFT_MAX : over_d;
    end
    exp_sum_d = SW'(exp_q) + SW'(shift_d);
    exp_d     = (exp_sum_d > SW'(EXP_MAX)) ? EXP_MAX : exp_sum_d[EXP_W-1:0];
  end

  // Stage sequencer; all outputs except the activate strobe are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      stage_start_q <= 1'b0;
      clr_q         <= 1'b1;
      stage_idx_q   <= '0;
      shift_q       <= '0;
      exp_q         <= '0;
      cnt_q         <= '0;
    end else begin
      done_q        <= 1'b0;
      stage_start_q <= 1'b0;
      clr_q         <= 1'b0;
      if (abort_i && state_q != S_IDLE) begin
        // Abort wins over every transition; the partial exponent is kept.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        clr_q   <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: if (start_i) begin
            stage_idx_q   <= '0;
            shift_q       <= '0;
            exp_q         <= '0;
            busy_q        <= 1'b1;
            stage_start_q <= 1'b1;
            clr_q         <= 1'b1;
            state_q       <= S_CLEAR;
          end
          S_CLEAR: begin
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
          S_RUN: if (bfly_valid_i) begin
            if (cnt_q == LAST_BFLY) state_q <= S_SETTLE;
            else                    cnt_q   <= cnt_q + 1'b1;
          end
          // The tracker registers the final activation one cycle late.
          S_SETTLE: state_q <= S_LATCH;
          S_LATCH: begin
            exp_q <= exp_d;
            if (stage_idx_q < LAST_STAGE) begin
              shift_q       <= shift_d;
              stage_idx_q   <= stage_idx_q + 1'b1;
              stage_start_q <= 1'b1;
              clr_q         <= 1'b1;
              state_q       <= S_CLEAR;
            end else begin
              // Last stage: the shift only normalises the exponent.
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tracker_activate_o = (state_q == S_RUN) && bfly_valid_i;
  assign tracker_clr_o      = clr_q;
  assign busy_o             = busy_q;
  assign stage_start_o      = stage_start_q;
  assign stage_idx_o        = stage_idx_q;
  assign stage_shift_o      = shift_q;
  assign block_exponent_o   = exp_q;
  assign done_o             = done_q;

endmodule

// File: tb/tb_bfp_stage_ctrl.sv
// Directed bench for bfp_stage_ctrl: 3 stages of 4 butterflies, 3-bit exponent.
module tb_bfp_stage_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort, bfly_valid;
  logic [4:0] tracker_max;
  logic       tracker_clr, tracker_activate, busy, stage_start, done;
  logic [1:0] stage_idx;
  logic [4:0] stage_shift;
  logic [2:0] block_exponent;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bfp_stage_ctrl #(
    .FFT_MAX_BIT_WIDTH(5), .NUM_STAGES(3), .STAGE_W(2), .BFLY_PER_STAGE(4),
    .BFLY_CNT_W(2), .TARGET_BIT_WIDTH(14), .MAX_SHIFT(3), .EXP_W(3)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start), .abort_i(abort),
    .bfly_valid_i(bfly_valid), .tracker_max_i(tracker_max),
    .tracker_clr_o(tracker_clr), .tracker_activate_o(tracker_activate),
    .busy_o(busy), .stage_start_o(stage_start), .stage_idx_o(stage_idx),
    .stage_shift_o(stage_shift), .block_exponent_o(block_exponent), .done_o(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one full transform; start is sampled in the current (IDLE) cycle.
  task automatic run_xform(input string tag, input logic [4:0] tm0, tm1, tm2,
                           input bit gaps, input bit hold_start,
                           input logic [4:0] sh1, sh2, input logic [2:0] exp_final);
    logic [4:0] tm [3];
    logic [4:0] sh [3];
    int acts, vld;
    tm = '{tm0, tm1, tm2};
    sh = '{5'd0, sh1, sh2};
    start = 1'b1;
    tick();
    start = hold_start;
    for (int s = 0; s < 3; s++) begin
      bfly_valid = gaps;
      #1;
      n_cmp++;
      if (stage_start !== 1'b1 || tracker_clr !== 1'b1 || busy !== 1'b1 ||
          tracker_activate !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s clear s%0d: start/clr/busy/act/done=%b%b%b%b%b want 11100",
                 tag, s, stage_start, tracker_clr, busy, tracker_activate, done);
      end
      n_cmp++;
      if (stage_idx !== s || stage_shift !== sh[s]) begin
        n_bad++;
        $display("FAIL %s stage s%0d: idx=%0d shift=%0d want idx=%0d shift=%0d",
                 tag, s, stage_idx, stage_shift, s, sh[s]);
      end
      tick();
      acts = 0;
      vld  = 0;
      for (int k = 0; k < 8 && vld < 4; k++) begin
        bfly_valid = gaps ? (k % 2 == 0) : 1'b1;
        #1;
        if (tracker_activate === 1'b1) acts++;
        if (bfly_valid) vld++;
        tick();
      end
      bfly_valid = gaps;
      #1;
      if (tracker_activate === 1'b1) acts++;
      n_cmp++;
      if (acts !== 4 || stage_start !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s act s%0d: pulses=%0d start=%b done=%b want 4 0 0",
                 tag, s, acts, stage_start, done);
      end
      tick();
      bfly_valid  = gaps;
      tracker_max = tm[s];
      tick();
      bfly_valid  = 1'b0;
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b1 || stage_idx !== 2'd2 || stage_shift !== sh2 ||
        block_exponent !== exp_final) begin
      n_bad++;
      $display("FAIL %s done: done=%b busy=%b idx=%0d shift=%0d exp=%0d want 1 1 2 %0d %0d",
               tag, done, busy, stage_idx, stage_shift, block_exponent, sh2, exp_final);
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || block_exponent !== exp_final) begin
      n_bad++;
      $display("FAIL %s post: busy=%b done=%b exp=%0d want 0 0 %0d",
               tag, busy, done, block_exponent, exp_final);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || stage_start !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle: busy=%b stage_start=%b want 0 0", tag, busy, stage_start);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; bfly_valid = 1'b0; tracker_max = '0;
    tick(); tick();
    n_cmp++;
    if (tracker_clr !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || stage_start !== 1'b0 ||
        tracker_activate !== 1'b0 || stage_idx !== 2'd0 || stage_shift !== 5'd0 ||
        block_exponent !== 3'd0) begin
      n_bad++;
      $display("FAIL reset: clr=%b busy=%b done=%b ss=%b act=%b idx=%0d sh=%0d exp=%0d want 1 0 0 0 0 0 0 0",
               tracker_clr, busy, done, stage_start, tracker_activate, stage_idx,
               stage_shift, block_exponent);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (tracker_clr !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: clr=%b busy=%b want 0 0", tracker_clr, busy);
    end
  endtask

  task automatic test_nominal();
    run_xform("nominal", 5'd12, 5'd12, 5'd12, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0);
  endtask

  task automatic test_growth();
    run_xform("growth", 5'd15, 5'd16, 5'd14, 1'b0, 1'b0, 5'd1, 5'd2, 3'd3);
  endtask

  task automatic test_saturation();
    run_xform("saturate", 5'd20, 5'd20, 5'd20, 1'b0, 1'b0, 5'd3, 5'd3, 3'd7);
  endtask

  task automatic test_gaps();
    run_xform("gaps", 5'd15, 5'd12, 5'd12, 1'b1, 1'b0, 5'd1, 5'd0, 3'd1);
  endtask

  task automatic test_start_busy();
    run_xform("start_busy", 5'd12, 5'd16, 5'd12, 1'b0, 1'b1, 5'd0, 5'd2, 3'd2);
  endtask

  // Walk into stage 1 with tracker_max=16 at the end of stage 0 (exponent 2).
  task automatic enter_stage1(input logic [4:0] tm);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bfly_valid = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    bfly_valid  = 1'b0;
    tick();
    tracker_max = tm;
    tick();
  endtask

  task automatic test_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || tracker_clr !== 1'b0 || stage_start !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: busy=%b clr=%b ss=%b want 0 0 0", busy, tracker_clr, stage_start);
    end
    enter_stage1(5'd16);
    n_cmp++;
    if (stage_idx !== 2'd1 || stage_shift !== 5'd2 || block_exponent !== 3'd2) begin
      n_bad++;
      $display("FAIL abort_pre: idx=%0d shift=%0d exp=%0d want 1 2 2", stage_idx, stage_shift, block_exponent);
    end
    tick();
    bfly_valid = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; bfly_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || tracker_clr !== 1'b1 || done !== 1'b0 || stage_start !== 1'b0 ||
        block_exponent !== 3'd2) begin
      n_bad++;
      $display("FAIL abort: busy=%b clr=%b done=%b ss=%b exp=%0d want 0 1 0 0 2",
               busy, tracker_clr, done, stage_start, block_exponent);
    end
    tick();
    n_cmp++;
    if (tracker_clr !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_after: clr=%b done=%b busy=%b want 0 0 0", tracker_clr, done, busy);
    end
    run_xform("after_abort", 5'd12, 5'd12, 5'd12, 1'b0, 1'b0, 5'd0, 5'd0, 3'd0);
  endtask

  task automatic test_reset_mid_run();
    enter_stage1(5'd15);
    n_cmp++;
    if (stage_idx !== 2'd1 || stage_shift !== 5'd1 || block_exponent !== 3'd1) begin
      n_bad++;
      $display("FAIL rst_pre: idx=%0d shift=%0d exp=%0d want 1 1 1", stage_idx, stage_shift, block_exponent);
    end
    tick();
    bfly_valid = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (tracker_clr !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || stage_start !== 1'b0 ||
        tracker_activate !== 1'b0 || stage_idx !== 2'd0 || stage_shift !== 5'd0 ||
        block_exponent !== 3'd0) begin
      n_bad++;
      $display("FAIL rst_mid: clr=%b busy=%b done=%b ss=%b act=%b idx=%0d sh=%0d exp=%0d want 1 0 0 0 0 0 0 0",
               tracker_clr, busy, done, stage_start, tracker_activate, stage_idx,
               stage_shift, block_exponent);
    end
    reset = 1'b0; bfly_valid = 1'b0;
    tick();
    n_cmp++;
    if (tracker_clr !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_release: clr=%b busy=%b want 0 0", tracker_clr, busy);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_growth();
    test_saturation();
    test_gaps();
    test_start_busy();
    test_abort();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bfp_stage_ctrl.md
Name: bfp_stage_ctrl

Overview:
Sequences block-floating-point scaling across the stages of the in-place FFT. For each stage it clears the max-bit-width tracker and gates the tracker's activate strobe with butterfly writes. At stage end it derives the shift to apply during the next stage from the tracker's result. It also accumulates the block exponent for the whole transform and sits between the FFT top-level sequencer and the butterfly/tracker datapath.

Parameters:
FFT_MAX_BIT_WIDTH, 5, width of bit-width values and of the shift output
NUM_STAGES, 10, FFT stages per transform (log2 N)
STAGE_W, 4, width of stage index; must hold NUM_STAGES-1
BFLY_PER_STAGE, 512, butterfly writes per stage (N/2)
BFLY_CNT_W, 10, butterfly counter width; must hold BFLY_PER_STAGE-1
TARGET_BIT_WIDTH, 14, largest magnitude width allowed without scaling
MAX_SHIFT, 3, saturation limit for a per-stage shift
EXP_W, 8, block exponent width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  begin a transform; sampled only in IDLE
abort  in  1  cancel the current transform
bfly_valid  in  1  butterfly datapath wrote one result this cycle
tracker_max  in  FFT_MAX_BIT_WIDTH  max bit width from the tracker
tracker_clr  out  1  clear the tracker
tracker_activate  out  1  tracker activate strobe
busy  out  1  transform in progress
stage_start  out  1  one-cycle pulse at the start of each stage
stage_idx  out  STAGE_W  current stage
stage_shift  out  FFT_MAX_BIT_WIDTH  right-shift the butterflies apply during stage_idx
block_exponent  out  EXP_W  accumulated shifts of the current/last transform
done  out  1  one-cycle pulse at transform completion

Behaviour:
- Reset values:
  - state=IDLE
  - busy=0, done=0, stage_start=0, tracker_activate=0
  - tracker_clr=1 while reset is asserted
  - stage_idx=0, stage_shift=0, block_exponent=0
- FSM states: IDLE, CLEAR, RUN, SETTLE, LATCH, DONE. All outputs are registered except tracker_activate.
- IDLE:
  - On start=1: zero stage_idx, stage_shift and block_exponent; go to CLEAR.
- CLEAR (1 cycle):
  - tracker_clr=1, stage_start=1, bfly counter=0; go to RUN.
- RUN:
  - tracker_activate = bfly_valid (combinational).
  - Each bfly_valid increments the counter.
  - When bfly_valid arrives with counter==BFLY_PER_STAGE-1, go to SETTLE.
  - No bfly_valid means stay in RUN with no timeout.
- SETTLE (1 cycle): exists because the tracker registers the last activation one cycle later.
- LATCH (1 cycle):
  - s = tracker_max > TARGET_BIT_WIDTH ? tracker_max - TARGET_BIT_WIDTH : 0, saturated to MAX_SHIFT.
  - block_exponent += s, saturating at 2^EXP_W-1.
  - If stage_idx < NUM_STAGES-1: stage_shift <= s, stage_idx++, go to CLEAR.
  - Otherwise go to DONE. stage_shift and stage_idx are held; s only updates block_exponent (output normalisation).
- DONE (1 cycle): done=1; go to IDLE.
- busy=1 in every state except IDLE. It drops in the cycle after done.
- Stage 0 always runs with stage_shift=0.
- tracker_activate=0 outside RUN: bfly_valid in any other state is ignored and not counted.
- start while busy is ignored.
- start in the same cycle done is high is ignored; the next start is accepted in IDLE.
- abort=1 in any non-IDLE state:
  - next state IDLE, tracker_clr=1 for that cycle, no done pulse.
  - block_exponent keeps its partial value.
  - abort in IDLE has no effect.
  - abort has priority over all transitions.
- reset mid-transform: same as abort, and all outputs return to their reset values.
- Minimum transform length: NUM_STAGES*(BFLY_PER_STAGE+3)+1 cycles, counted from the cycle after start is sampled up to and including the done cycle.

Test Plan:
- Nominal, params NUM_STAGES=3, BFLY_PER_STAGE=4; tracker_max=12 every stage; continuous bfly_valid -> stage_shift=0 all stages; block_exponent=0; done pulses exactly 3*(4+3)+1=22 cycles after the start cycle; busy 0 the cycle after done.
- Growth: tracker_max 15,16,14 at stage ends -> stage_shift 1 in stage 1 and 2 in stage 2; final block_exponent=3.
- Saturation: tracker_max=20 with MAX_SHIFT=3 and EXP_W=3, across 3 stages -> per-stage s=3; block_exponent saturates at 7.
- Gaps: bfly_valid toggling 1/0, plus extra bfly_valid during CLEAR/SETTLE -> exactly 4 tracker_activate pulses per stage; stray pulses ignored.
- Abort: assert abort on the 2nd bfly_valid of stage 1 -> IDLE next cycle; tracker_clr=1 that cycle; no done; new start runs cleanly from stage 0.
- Start while busy, and reset mid-RUN: start ignored with no state change; reset restores all reset values.
